// File: rtl/aes128_round_engine.sv
// rtl/aes128_round_engine.sv - iterative AES-128 encryption engine, one round per clock

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

    // Inverse as x^254 via an addition chain; zero maps to zero naturally.
    always_comb begin
        w_x2   = gf_mul(in, in);
        w_x3   = gf_mul(w_x2, in);
        w_x6   = gf_mul(w_x3, w_x3);
        w_x12  = gf_mul(w_x6, w_x6);
        w_x15  = gf_mul(w_x12, w_x3);
        w_x30  = gf_mul(w_x15, w_x15);
        w_x60  = gf_mul(w_x30, w_x30);
        w_x120 = gf_mul(w_x60, w_x60);
        w_x240 = gf_mul(w_x120, w_x120);
        w_x252 = gf_mul(w_x240, w_x12);
        w_inv  = gf_mul(w_x252, w_x2);
    end

    assign out = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;

endmodule

module aes128_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1407:0] i_round_keys,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [127:0]  i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [127:0]  o_out_data,
    output logic          o_busy
);

    localparam logic [3:0] LP_LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [127:0] r_state_reg;
    logic [3:0]   r_round;
    logic [127:0] r_out_data;
    logic         r_out_valid;
    logic         r_busy;

    logic [127:0] w_rk [0:10];
    logic [3:0]   w_rk_idx;
    logic [127:0] w_cur_rk;
    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_round_mid;
    logic [127:0] w_round_last;
    logic         w_in_ready;
    logic         w_last_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Row n of the column-major state rotates left by n columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    genvar g;
    generate
        for (g = 0; g <= 10; g++) begin : g_rk
            assign w_rk[g] = i_round_keys[1407 - 128*g -: 128];
        end
        for (g = 0; g < 16; g++) begin : g_sbox
            aes_sbox u_sbox (
                .in  (r_state_reg[127 - 8*g -: 8]),
                .out (w_sub[127 - 8*g -: 8])
            );
        end
    endgenerate

    // Unreachable counter values above the last round are treated as the last round.
    assign w_last_round = (r_round >= LP_LAST);
    assign w_rk_idx     = w_last_round ? LP_LAST : r_round;
    assign w_cur_rk     = w_rk[w_rk_idx];
    assign w_shift      = shift_rows(w_sub);
    assign w_round_mid  = mix_columns(w_shift) ^ w_cur_rk;
    assign w_round_last = w_shift ^ w_cur_rk;

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);

    // Control FSM and datapath registers: load, nine full rounds, final round, hold result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_state_reg <= '0;
            r_round     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_state_reg <= i_in_data ^ w_rk[0];
                        r_round     <= 4'd1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last_round) begin
                        r_out_data  <= w_round_last;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state_reg <= w_round_mid;
                        r_round     <= r_round + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (i_in_valid) begin
                            r_state_reg <= i_in_data ^ w_rk[0];
                            r_round     <= 4'd1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_aes128_round_engine.sv
// tb/tb_aes128_round_engine.sv - scoreboard bench for aes128_round_engine against a byte-level AES model
module tb_aes128_round_engine;

    logic          clk;
    logic          rst_n;
    logic [1407:0] round_keys;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           rise_q[$];
    logic         prev_ov = 1'b0;

    logic [7:0] sb_t  [256];
    logic [7:0] exp_t [255];
    int         log_t [256];
    logic [7:0] mcoef [16];

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_round_engine #(.NUM_ROUNDS(10)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_round_keys (round_keys),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    task automatic init_tables();
        logic [7:0] p;
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        int         m [16];
        m = '{2, 3, 1, 1, 1, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 2};
        for (int i = 0; i < 16; i++) mcoef[i] = 8'(m[i]);
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = i;
            p = gmul(p, 8'h03);
        end
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
            for (int i = 0; i < 8; i++) begin
                r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb_t[x] = r;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] rk;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) rk[1407 - 32*i -: 32] = w[i];
        return rk;
    endfunction

    function automatic logic [127:0] encrypt(input logic [1407:0] rk, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[1407 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = s[r + 4*((c + r) % 4)];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(mcoef[4*r + j], s[4*c + j]);
                        t[r + 4*c] = acc;
                    end
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1407 - 128*rnd - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(encrypt(round_keys, in_data));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_ov) begin
                rise_q.push_back(cyc);
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency: out_valid rose at cycle %0d with no accepted block", cyc);
                end else begin
                    int a;
                    a = acc_q.pop_front();
                    if (cyc - a != 10) begin
                        errors++;
                        $display("FAIL latency: got %0d edges, expected 10", cyc - a);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ciphertext: unexpected output %h", out_data);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL ciphertext: got %h expected %h", out_data, e);
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [127:0] pt);
        bit ok;
        ok = 0;
        in_data  = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept", 128'(ok), 128'd1);
    endtask

    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("wait_out_valid", 128'(ok), 128'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 128'(ok), 128'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [127:0] k;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        round_keys = '0;
        out_ready  = 1'b1;
        init_tables();

        chk("model_kat1", encrypt(expand_key(K1), P1), C1);
        chk("model_kat2", encrypt(expand_key(K2), P2), C2);
        chk("model_kat3", encrypt(expand_key(128'd0), 128'd0), C3);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;

        // Vector 1 and vector 2
        round_keys = expand_key(K1);
        send(P1);
        drain();
        round_keys = expand_key(K2);
        send(P2);
        drain();

        // All-zero vector with output back-pressure
        round_keys = expand_key(128'd0);
        out_ready  = 1'b0;
        send(128'd0);
        wait_out();
        in_data  = rnd128();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_out_data", out_data, C3);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("after_stall_idle_ready", 128'(in_ready), 128'd1);
        chk("after_stall_busy", 128'(busy), 128'd0);

        // Back-to-back: vector 1 then vector 2
        round_keys = expand_key(K1);
        n0         = rise_q.size();
        send(P1);
        in_data  = P2;
        in_valid = 1'b1;
        wait_out();
        round_keys = expand_key(K2);
        chk("b2b_in_ready_done", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_busy", 128'(busy), 128'd1);
        drain();
        checks++;
        if (rise_q.size() < n0 + 2) begin
            errors++;
            $display("FAIL b2b_spacing: only %0d outputs seen", rise_q.size() - n0);
        end else if (rise_q[n0 + 1] - rise_q[n0] != 11) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 11", rise_q[n0 + 1] - rise_q[n0]);
        end

        // Reset in the middle of a block
        round_keys = expand_key(K1);
        send(rnd128());
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(P1);
        drain();

        // in_valid while busy is ignored
        k          = rnd128();
        round_keys = expand_key(k);
        send(rnd128());
        for (int i = 0; i < 3; i++) begin
            in_data  = rnd128();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("busy_high", 128'(busy), 128'd1);
            chk("busy_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        drain();

        // Randomized blocks with random output stalls
        for (int it = 0; it < 8; it++) begin
            k          = rnd128();
            round_keys = expand_key(k);
            out_ready  = 1'($urandom_range(0, 1));
            send(rnd128());
            wait_out();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            drain();
        end

        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
